// File: rtl/intc_arbiter.sv
// intc_arbiter: fixed-priority interrupt controller for up to eight sources.
// Each source is edge-detected and latched as pending, gated by MASK, and the
// lowest pending+enabled index is offered to the CPU on INT. The CPU services
// one interrupt at a time; an EOI write ends service.
// Build option: define INTC_SYNC_EN to add a 2-flop synchronizer per source
// (for switch/button inputs); without it irq_src must be synchronous to clk.
// Register window (addr_bus[3:2]): 0 PENDING (W1C), 1 MASK, 2 CAUSE (RO), 3 EOI.
module intc_arbiter #(
   parameter int          NSRC      = 8,
   parameter logic [31:0] BASE_ADDR = 32'hD000_0000
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NSRC-1:0] irq_src,
   input  logic            int_ack,
   input  logic [31:0]     addr_bus,
   input  logic            mem_w,
   input  logic [31:0]     Cpu_data2bus,
   output logic [31:0]     intc_rdata,
   output logic            intc_sel,
   output logic            INT,
   output logic [2:0]      int_id,
   output logic            in_service
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [NSRC-1:0] src_s;
   logic [NSRC-1:0] src_prev;
   logic [NSRC-1:0] src_edge;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] req;
   logic [NSRC-1:0] w1c_clr;
   logic [NSRC-1:0] ack_clr;
   logic [2:0]      winner;
   logic            wr_en, wr_pend, wr_mask, wr_eoi;
   logic            ack_take;
   logic [31:0]     pend_ext, mask_ext;
   logic            unused_bits;

   // Address bits below the word offset and data bits above NSRC carry no meaning here.
   assign unused_bits = ^{addr_bus[1:0], Cpu_data2bus[31:NSRC]};

   assign intc_sel = (addr_bus[31:4] == BASE_ADDR[31:4]);
   assign wr_en    = mem_w & intc_sel;
   assign wr_pend  = wr_en & (addr_bus[3:2] == 2'd0);
   assign wr_mask  = wr_en & (addr_bus[3:2] == 2'd1);
   assign wr_eoi   = wr_en & (addr_bus[3:2] == 2'd3);

`ifdef INTC_SYNC_EN
   logic [NSRC-1:0] sync_q1, sync_q2;

   // Two-flop synchronizer for asynchronous sources (switches, buttons).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq_src;
         sync_q2 <= sync_q1;
      end
   end

   assign src_s = sync_q2;
`else
   assign src_s = irq_src;
`endif

   assign src_edge = src_s & ~src_prev;
   assign req      = pending & mask;
   assign ack_take = (state == S_REQ) && int_ack && (req != '0);
   assign w1c_clr  = wr_pend ? Cpu_data2bus[NSRC-1:0] : '0;

   // Priority encoder: scanning downward leaves the lowest set index as winner.
   always_comb begin
      winner = 3'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) winner = 3'(i);
      end
   end

   // One-hot clear for the bit being acknowledged.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NSRC; i++) begin
         ack_clr[i] = ack_take && (winner == 3'(i));
      end
   end

   // Previous-sample register for edge detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) src_prev <= '0;
      else       src_prev <= src_s;
   end

   // Pending latch: a same-cycle edge overrides both W1C and acknowledge clears.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) pending <= '0;
      else       pending <= (pending & ~w1c_clr & ~ack_clr) | src_edge;
   end

   // MASK register, enable bit per source.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        mask <= '0;
      else if (wr_mask) mask <= Cpu_data2bus[NSRC-1:0];
   end

   // In-service ID captured at acknowledge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)         int_id <= 3'd0;
      else if (ack_take) int_id <= winner;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nx;
   end

   // FSM next-state: no nesting, so SERVICE waits only for EOI.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (req != '0) state_nx = S_REQ;
         S_REQ: begin
            if (req == '0)   state_nx = S_IDLE;
            else if (int_ack) state_nx = S_SERVICE;
         end
         S_SERVICE: if (wr_eoi) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // FSM outputs decoded from the state register, so INT is a registered request.
   always_comb begin
      INT        = (state == S_REQ);
      in_service = (state == S_SERVICE);
   end

   // Read mux: zero-latency, zero when the window is not selected.
   always_comb begin
      pend_ext             = '0;
      mask_ext             = '0;
      pend_ext[NSRC-1:0]   = pending;
      mask_ext[NSRC-1:0]   = mask;
      intc_rdata           = '0;
      if (intc_sel) begin
         case (addr_bus[3:2])
            2'd0:    intc_rdata = pend_ext;
            2'd1:    intc_rdata = mask_ext;
            2'd2:    intc_rdata = {in_service, 28'b0, int_id};
            default: intc_rdata = '0;
         endcase
      end
   end

endmodule
